ad1939_adc_deserializer: RTL and testbench

Receive-side stage directly downstream of the AD1939 physical ADC pins (asdata2, abclk, alrclk). Oversamples the codec's I2S bit clock, frame clock and serial data in the fabric clock domain. Deserializes each left/right slot into a parallel sample and presents it on an Avalon-ST source, with a 2-entry output buffer, for the audio processing chain ahead of the DAC serializer.

---
 rtl/ad1939_adc_deserializer.sv | 155 +++++++++++++++
 tb/tb_ad1939_adc_deserializer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ad1939_adc_deserializer.sv
`timescale 1ns/1ps
// AD1939 I2S ADC receiver: oversamples abclk/alrclk/asdata, deserializes slots into a 2-entry Avalon-ST buffer.
// Optional slot-length checking (frame_error port) is enabled by defining AD1939_DESER_FRAME_CHECK_EN.
module ad1939_adc_deserializer #(
  parameter int DATA_WIDTH  = 24,
  parameter int SLOT_BITS   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  abclk,
  input  logic                  alrclk,
  input  logic                  asdata,
  output logic [DATA_WIDTH-1:0] avalon_streaming_source_data,
  output logic                  avalon_streaming_source_channel,
  output logic                  avalon_streaming_source_valid,
  input  logic                  avalon_streaming_source_ready,
  output logic                  overflow
`ifdef AD1939_DESER_FRAME_CHECK_EN
  ,
  output logic                  frame_error
`endif
);

  localparam int CW = $clog2(SLOT_BITS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SLOT_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PAD} state_t;

  logic [SYNC_STAGES-1:0] bclk_sync, lr_sync, sd_sync;
  logic                   bclk_prev, bclk_rise, lr, sd, lr_prev, lr_edge;

  state_t                 state, state_next;
  logic [CW-1:0]          bit_cnt, bit_cnt_next;
  logic [DATA_WIDTH-1:0]  shreg, shreg_next;
  logic                   ch, ch_next, push;

  logic [DATA_WIDTH:0]    mem [2];
  logic                   wr_ptr, rd_ptr, full, pop, do_push, drop;
  logic [1:0]             count;

  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sync <= '0;
      lr_sync   <= '0;
      sd_sync   <= '0;
      bclk_prev <= 1'b0;
      lr_prev   <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], abclk};
      lr_sync   <= {lr_sync[SYNC_STAGES-2:0], alrclk};
      sd_sync   <= {sd_sync[SYNC_STAGES-2:0], asdata};
      bclk_prev <= bclk_sync[SYNC_STAGES-1];
      if (bclk_rise) lr_prev <= lr;
    end
  end

  assign bclk_rise = bclk_sync[SYNC_STAGES-1] & ~bclk_prev;
  assign lr        = lr_sync[SYNC_STAGES-1];
  assign sd        = sd_sync[SYNC_STAGES-1];
  assign lr_edge   = bclk_rise & (lr != lr_prev);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      ch      <= 1'b0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      shreg   <= shreg_next;
      ch      <= ch_next;
    end
  end

  // Any LR edge (re)starts a slot; the rise carrying the edge is the I2S delay bit.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shreg_next   = shreg;
    ch_next      = ch;
    push         = 1'b0;
    if (bclk_rise) begin
      if (lr_edge) begin
        state_next   = SHIFT;
        bit_cnt_next = '0;
        shreg_next   = '0;
        ch_next      = lr;
      end else if (state == SHIFT) begin
        shreg_next   = {shreg[DATA_WIDTH-2:0], sd};
        bit_cnt_next = (bit_cnt == CNT_MAX) ? bit_cnt : bit_cnt + 1'b1;
        if (bit_cnt == CNT_LAST) begin
          push       = 1'b1;
          state_next = PAD;
        end
      end
    end
  end

  assign full    = (count == 2'd2);
  assign pop     = avalon_streaming_source_valid & avalon_streaming_source_ready;
  assign do_push = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= {shreg_next, ch};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({do_push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  assign avalon_streaming_source_valid   = (count != 2'd0);
  assign avalon_streaming_source_data    = mem[rd_ptr][DATA_WIDTH:1];
  assign avalon_streaming_source_channel = mem[rd_ptr][0];

`ifdef AD1939_DESER_FRAME_CHECK_EN
  localparam int SW = $clog2(SLOT_BITS + 2);
  logic [SW-1:0] slot_cnt;

  // slot_cnt counts rises since the last edge, including the edge rise itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt    <= '0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      if (lr_edge) begin
        frame_error <= (state != IDLE) && (slot_cnt != SW'(SLOT_BITS));
        slot_cnt    <= SW'(1);
      end else if (bclk_rise && slot_cnt != SW'(SLOT_BITS + 1)) begin
        slot_cnt    <= slot_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ad1939_adc_deserializer.sv
`timescale 1ns/1ps
// Bench for ad1939_adc_deserializer: table of I2S slots plus hand-written overflow, same-cycle push/pop and reset sequences.
module tb_ad1939_adc_deserializer;
  localparam int DW   = 24;
  localparam int HALF = 8;

  logic          clk = 1'b0;
  logic          reset, abclk, alrclk, asdata, ready;
  logic [DW-1:0] data;
  logic          channel, valid, overflow;
`ifdef AD1939_DESER_FRAME_CHECK_EN
  logic          frame_error;
  int            fe_cnt = 0;
`endif

  int            compared = 0;
  int            mismatched = 0;
  logic [DW:0]   exp_q[$];
  logic [DW:0]   mon_e;

  typedef struct {
    logic          ch;
    logic [DW-1:0] data;
    logic          pad;
    int            nbits;
    bit            emit;
    logic [DW-1:0] exp_data;
  } slot_t;
  slot_t tbl[9];

  always #10 clk = ~clk;

  ad1939_adc_deserializer dut (
    .clk                             (clk),
    .reset                           (reset),
    .abclk                           (abclk),
    .alrclk                          (alrclk),
    .asdata                          (asdata),
    .avalon_streaming_source_data    (data),
    .avalon_streaming_source_channel (channel),
    .avalon_streaming_source_valid   (valid),
    .avalon_streaming_source_ready   (ready),
    .overflow                        (overflow)
`ifdef AD1939_DESER_FRAME_CHECK_EN
    ,
    .frame_error                     (frame_error)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted beat must match the head of exp_q.
  always begin
    @(negedge clk);
    #5;
    if (valid === 1'b1 && ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_beat: got ch %0d data %06h, expected no beat", channel, data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("beat_data", 32'(data), 32'(mon_e[DW:1]));
        chk("beat_channel", 32'(channel), 32'(mon_e[0]));
      end
    end
`ifdef AD1939_DESER_FRAME_CHECK_EN
    if (frame_error === 1'b1) fe_cnt++;
`endif
  end

  // mode 0: plain bit, 1: ready pulse on the push cycle of this rise, 2: reset pulse in low phase
  task automatic send_bit(input logic lr, input logic sd, input int mode);
    abclk = 1'b0; alrclk = lr; asdata = sd;
    if (mode == 2) begin
      repeat (3) @(negedge clk);
      chk("pre_reset_valid", 32'(valid), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("post_reset_valid", 32'(valid), 32'd0);
      chk("post_reset_overflow", 32'(overflow), 32'd0);
      repeat (HALF - 4) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    abclk = 1'b1;
    if (mode == 1) begin
      repeat (2) @(negedge clk);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      repeat (HALF - 3) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic send_slot(input logic ch, input logic [DW-1:0] d, input logic pad,
                           input int nbits, input int mode_at, input int mode);
    for (int i = 0; i < nbits; i++) begin
      logic b;
      b = (i >= 1 && i <= DW) ? d[DW-i] : pad;
      send_bit(ch, b, (i == mode_at) ? mode : 0);
    end
  endtask

  task automatic idle_reset();
    abclk = 1'b0; alrclk = 1'b0; asdata = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; abclk = 1'b0; alrclk = 1'b0; asdata = 1'b0; ready = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_data", 32'(data), 32'd0);
    chk("reset_channel", 32'(channel), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);

    // partial left slot after reset, full stereo frames, negative with pad=1, short slot
    tbl[0] = '{1'b0, 24'h0F0F0F, 1'b0, 10, 1'b0, 24'h000000};
    tbl[1] = '{1'b1, 24'h5A5A5A, 1'b0, 32, 1'b1, 24'h5A5A5A};
    tbl[2] = '{1'b0, 24'hA5C3F1, 1'b0, 32, 1'b1, 24'hA5C3F1};
    tbl[3] = '{1'b1, 24'h123456, 1'b0, 32, 1'b1, 24'h123456};
    tbl[4] = '{1'b0, 24'h800001, 1'b1, 32, 1'b1, 24'h800001};
    tbl[5] = '{1'b1, 24'h7FFFFF, 1'b0, 32, 1'b1, 24'h7FFFFF};
    tbl[6] = '{1'b0, 24'h0FF00F, 1'b1, 20, 1'b0, 24'h000000};
    tbl[7] = '{1'b1, 24'h3C3C3C, 1'b0, 32, 1'b1, 24'h3C3C3C};
    tbl[8] = '{1'b0, 24'h000000, 1'b1, 32, 1'b1, 24'h000000};
    for (int k = 0; k < 9; k++) begin
      if (tbl[k].emit) exp_q.push_back({tbl[k].exp_data, tbl[k].ch});
      send_slot(tbl[k].ch, tbl[k].data, tbl[k].pad, tbl[k].nbits, -1, 0);
    end
    repeat (20) @(negedge clk);
    chk("table_drained", 32'(exp_q.size()), 32'd0);
    chk("table_overflow", 32'(overflow), 32'd0);
`ifdef AD1939_DESER_FRAME_CHECK_EN
    chk("frame_error_pulses", 32'(fe_cnt), 32'd1);
`endif

    // overflow: three slots completed with ready low
    ready = 1'b0;
    send_slot(1'b1, 24'h111111, 1'b0, 32, -1, 0);
    send_slot(1'b0, 24'h222222, 1'b0, 32, -1, 0);
    chk("full_overflow", 32'(overflow), 32'd0);
    send_slot(1'b1, 24'h333333, 1'b0, 32, -1, 0);
    chk("drop_overflow", 32'(overflow), 32'd1);
    chk("drop_head_data", 32'(data), 32'h111111);
    chk("drop_head_channel", 32'(channel), 32'd1);
    exp_q.push_back({24'h111111, 1'b1});
    exp_q.push_back({24'h222222, 1'b0});
    ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("ovf_drained", 32'(exp_q.size()), 32'd0);
    chk("ovf_valid_low", 32'(valid), 32'd0);
    exp_q.push_back({24'h444444, 1'b0});
    send_slot(1'b0, 24'h444444, 1'b0, 32, -1, 0);
    repeat (20) @(negedge clk);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_after_drained", 32'(exp_q.size()), 32'd0);

    // push and pop in the same cycle while full
    idle_reset();
    chk("rst_clears_overflow", 32'(overflow), 32'd0);
    ready = 1'b0;
    exp_q.push_back({24'hAAAAAA, 1'b1});
    exp_q.push_back({24'hBBBBBB, 1'b0});
    exp_q.push_back({24'hCCCCCC, 1'b1});
    send_slot(1'b1, 24'hAAAAAA, 1'b0, 32, -1, 0);
    send_slot(1'b0, 24'hBBBBBB, 1'b0, 32, -1, 0);
    send_slot(1'b1, 24'hCCCCCC, 1'b0, 32, 24, 1);
    chk("pushpop_overflow", 32'(overflow), 32'd0);
    chk("pushpop_one_popped", 32'(exp_q.size()), 32'd2);
    chk("pushpop_head", 32'(data), 32'hBBBBBB);
    ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("pushpop_drained", 32'(exp_q.size()), 32'd0);

    // reset in the middle of a left slot with buffered words
    ready = 1'b0;
    send_slot(1'b0, 24'hDDDDDD, 1'b0, 32, -1, 0);
    send_slot(1'b1, 24'hEEEEEE, 1'b0, 32, -1, 0);
    send_slot(1'b0, 24'h0F0F0F, 1'b0, 32, 10, 2);
    chk("after_reset_slot_valid", 32'(valid), 32'd0);
    ready = 1'b1;
    exp_q.push_back({24'h654321, 1'b1});
    exp_q.push_back({24'h0ABCDE, 1'b0});
    send_slot(1'b1, 24'h654321, 1'b0, 32, -1, 0);
    send_slot(1'b0, 24'h0ABCDE, 1'b0, 32, -1, 0);
    repeat (20) @(negedge clk);
    chk("reset_resume_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
